// File: rtl/pcie_csr_pkg.sv
// Shared types and constants for the PCIe feature-region CSR target.
package pcie_csr_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned STAT_W = 32;

  // Byte offsets of the implemented registers inside the 4 KB window
  localparam int unsigned PCIE_DFH        = 'h0;
  localparam int unsigned PCIE_SCRATCHPAD = 'h8;
  localparam int unsigned PCIE_STAT       = 'h10;

  localparam logic [RESP_W-1:0] OKAY = 2'b00;

  // Device feature header layout
  typedef struct packed {
    logic [3:0]  feature_type;
    logic [18:0] rsvd;
    logic        eol;
    logic [23:0] next_offset;
    logic [3:0]  rev;
    logic [11:0] id;
  } dfh_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_RESP,
    RD_RESP
  } state_e;

  typedef enum logic {
    SRV_WR,
    SRV_RD
  } served_e;

endpackage

// File: rtl/pcie_csr_slave_if.sv
// AXI4-Lite CSR bus bundle between the host fabric and the feature target.
interface pcie_csr_slave_if #(
  parameter int unsigned ADDR_W = 12
);
  import pcie_csr_pkg::*;

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic                bvalid;
  logic                bready;
  logic [RESP_W-1:0]   bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [RESP_W-1:0]   rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/pcie_csr_regfile.sv
// Register storage, qword decode, byte-strobe merge and sticky error tracking.
module pcie_csr_regfile
  import pcie_csr_pkg::*;
#(
  parameter int unsigned ADDR_W          = 12,
  parameter logic [11:0] FEATURE_ID      = 12'h020,
  parameter logic [3:0]  FEATURE_REV     = 4'h0,
  parameter logic [23:0] NEXT_DFH_OFFSET = 24'h1000,
  parameter logic        END_OF_LIST     = 1'b0,
  parameter logic [3:0]  FEATURE_TYPE    = 4'h3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-4:0]  wr_qw,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [STRB_W-1:0]  wstrb,
  input  logic               rd_en,
  input  logic [ADDR_W-4:0]  rd_qw,
  input  logic [STAT_W-1:0]  stat_live,
  input  logic [STAT_W-1:0]  err_event,
  output logic [DATA_W-1:0]  rdata
);

  localparam int unsigned QW_W = ADDR_W - 3;
  localparam logic [QW_W-1:0] QW_DFH     = QW_W'(PCIE_DFH >> 3);
  localparam logic [QW_W-1:0] QW_SCRATCH = QW_W'(PCIE_SCRATCHPAD >> 3);
  localparam logic [QW_W-1:0] QW_STAT    = QW_W'(PCIE_STAT >> 3);

  dfh_t              dfh;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] scratch_d;
  logic [DATA_W-1:0] byte_mask;
  logic [STAT_W-1:0] sticky;
  logic [STAT_W-1:0] sticky_d;
  logic [STAT_W-1:0] clr_mask;
  logic [DATA_W-1:0] rd_val;

  // Constant feature header assembled from parameters
  always_comb begin
    dfh              = '0;
    dfh.feature_type = FEATURE_TYPE;
    dfh.eol          = END_OF_LIST;
    dfh.next_offset  = NEXT_DFH_OFFSET;
    dfh.rev          = FEATURE_REV;
    dfh.id           = FEATURE_ID;
  end

  // Expand byte strobes into a bit mask
  always_comb begin
    byte_mask = {{8{wstrb[7]}}, {8{wstrb[6]}}, {8{wstrb[5]}}, {8{wstrb[4]}},
                 {8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  end

  // Scratchpad byte merge and W1C clear mask
  always_comb begin
    scratch_d = scratch;
    clr_mask  = '0;
    if (wr_en && (wr_qw == QW_SCRATCH)) begin
      scratch_d = (scratch & ~byte_mask) | (wdata & byte_mask);
    end
    if (wr_en && (wr_qw == QW_STAT)) begin
      clr_mask = wdata[DATA_W-1:STAT_W] & byte_mask[DATA_W-1:STAT_W];
    end
    // New events are applied after the clear so a coincident set wins
    sticky_d = (sticky & ~clr_mask) | err_event;
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    rd_val = '0;
    if (rd_qw == QW_DFH) begin
      rd_val = dfh;
    end else if (rd_qw == QW_SCRATCH) begin
      rd_val = scratch;
    end else if (rd_qw == QW_STAT) begin
      rd_val = {sticky, stat_live};
    end
  end

  // Register state and read-data capture at the read accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      sticky  <= '0;
      rdata   <= '0;
    end else begin
      scratch <= scratch_d;
      sticky  <= sticky_d;
      if (rd_en) begin
        rdata <= rd_val;
      end
    end
  end

endmodule

// File: rtl/pcie_csr_slave.sv
// AXI4-Lite CSR target: single-outstanding handshake FSM with fair W/R arbiter.
module pcie_csr_slave
  import pcie_csr_pkg::*;
#(
  parameter int unsigned ADDR_W          = 12,
  parameter logic [11:0] FEATURE_ID      = 12'h020,
  parameter logic [3:0]  FEATURE_REV     = 4'h0,
  parameter logic [23:0] NEXT_DFH_OFFSET = 24'h1000,
  parameter logic        END_OF_LIST     = 1'b0,
  parameter logic [3:0]  FEATURE_TYPE    = 4'h3
) (
  input  logic                clk,
  input  logic                rst_n,
  pcie_csr_slave_if.slave     bus,
  input  logic [STAT_W-1:0]   stat_live,
  input  logic [STAT_W-1:0]   err_event
);

  state_e            state;
  state_e            state_d;
  served_e           last_served;
  served_e           last_served_d;
  logic              bvalid_q;
  logic              bvalid_d;
  logic              rvalid_q;
  logic              rvalid_d;
  logic              wr_req;
  logic              rd_req;
  logic              wr_grant_c;
  logic              rd_grant_c;
  logic [DATA_W-1:0] rdata_q;
  logic              unused_addr_bits;

  assign wr_req = bus.awvalid && bus.wvalid;
  assign rd_req = bus.arvalid;

  // Next-state, arbitration and grant decode
  always_comb begin
    state_d       = state;
    last_served_d = last_served;
    bvalid_d      = bvalid_q;
    rvalid_d      = rvalid_q;
    wr_grant_c    = 1'b0;
    rd_grant_c    = 1'b0;
    case (state)
      IDLE: begin
        // Grants are held off while in reset so readies drop asynchronously
        if (rst_n) begin
          if (wr_req && (!rd_req || (last_served == SRV_RD))) begin
            wr_grant_c    = 1'b1;
            state_d       = WR_RESP;
            bvalid_d      = 1'b1;
            last_served_d = SRV_WR;
          end else if (rd_req) begin
            rd_grant_c    = 1'b1;
            state_d       = RD_RESP;
            rvalid_d      = 1'b1;
            last_served_d = SRV_RD;
          end
        end
      end
      WR_RESP: begin
        if (bus.bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      RD_RESP: begin
        if (bus.rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        bvalid_d = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // FSM state, arbiter history and response valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= SRV_RD;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state       <= state_d;
      last_served <= last_served_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
    end
  end

  pcie_csr_regfile #(
    .ADDR_W          (ADDR_W),
    .FEATURE_ID      (FEATURE_ID),
    .FEATURE_REV     (FEATURE_REV),
    .NEXT_DFH_OFFSET (NEXT_DFH_OFFSET),
    .END_OF_LIST     (END_OF_LIST),
    .FEATURE_TYPE    (FEATURE_TYPE)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_grant_c),
    .wr_qw     (bus.awaddr[ADDR_W-1:3]),
    .wdata     (bus.wdata),
    .wstrb     (bus.wstrb),
    .rd_en     (rd_grant_c),
    .rd_qw     (bus.araddr[ADDR_W-1:3]),
    .stat_live (stat_live),
    .err_event (err_event),
    .rdata     (rdata_q)
  );

  // Sub-qword address bits carry no meaning for 64-bit registers
  assign unused_addr_bits = ^{bus.awaddr[2:0], bus.araddr[2:0]};

  assign bus.awready = wr_grant_c;
  assign bus.wready  = wr_grant_c;
  assign bus.arready = rd_grant_c;
  assign bus.bvalid  = bvalid_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.bresp   = OKAY;
  assign bus.rresp   = OKAY;

endmodule
